// File: rtl/philv_pkg.sv
// Shared constants for the PhilosophyV decode/execute slice: opcodes, load
// widths, ALU function codes, operand-select encodings and instruction fields.
package philv_pkg;

    localparam int ALU_FUNCT_WIDTH = 4;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

    localparam logic [2:0] LD_B  = 3'b000;
    localparam logic [2:0] LD_H  = 3'b001;
    localparam logic [2:0] LD_W  = 3'b010;
    localparam logic [2:0] LD_BU = 3'b100;
    localparam logic [2:0] LD_HU = 3'b101;

    // {instr[30], funct3}
    localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_ADD  = 4'b0000;
    localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_SUB  = 4'b1000;
    localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_SLL  = 4'b0001;
    localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_SLT  = 4'b0010;
    localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_SLTU = 4'b0011;
    localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_XOR  = 4'b0100;
    localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_SRL  = 4'b0101;
    localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_SRA  = 4'b1101;
    localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_OR   = 4'b0110;
    localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_AND  = 4'b0111;

    localparam logic       SRC_A_PC   = 1'b0;
    localparam logic       SRC_A_RS1  = 1'b1;
    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_FOUR = 2'b01;
    localparam logic [1:0] SRC_B_IMM  = 2'b10;
    localparam logic [1:0] SRC_B_ZERO = 2'b11;

    localparam int OPC_MSB = 6,  OPC_LSB = 0;
    localparam int RD_MSB  = 11, RD_LSB  = 7;
    localparam int F3_MSB  = 14, F3_LSB  = 12;
    localparam int RS1_MSB = 19, RS1_LSB = 15;
    localparam int RS2_MSB = 24, RS2_LSB = 20;
    localparam int ALT_BIT = 30;

endpackage

// File: rtl/philv_alu_core.sv
// Combinational RV32I ALU; codes outside the defined set produce zero.
module philv_alu_core
    import philv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [ALU_FUNCT_WIDTH-1:0] funct,
    input  logic [WIDTH-1:0]           x,
    input  logic [WIDTH-1:0]           y,
    output logic [WIDTH-1:0]           z
);

    logic [4:0] shamt;
    assign shamt = y[4:0];

    always_comb begin
        z = '0;
        case (funct)
            ALU_ADD:  z = x + y;
            ALU_SUB:  z = x - y;
            ALU_SLL:  z = x << shamt;
            ALU_SLT:  z = {{(WIDTH-1){1'b0}}, $signed(x) < $signed(y)};
            ALU_SLTU: z = {{(WIDTH-1){1'b0}}, x < y};
            ALU_XOR:  z = x ^ y;
            ALU_SRL:  z = x >> shamt;
            ALU_SRA:  z = $signed(x) >>> shamt;
            ALU_OR:   z = x | y;
            ALU_AND:  z = x & y;
            default:  z = '0;
        endcase
    end

endmodule

// File: rtl/philv_decode_exec.sv
// PhilosophyV decode/execute slice: field split, immediate, ALU and load format.
// Define PHILV_ALU_ZERO_FLAG_EN to add alu_zero / ex_zero for branch resolution.
module philv_decode_exec #(
    parameter int BUS_WIDTH       = 32,
    parameter int ALU_FUNCT_WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [31:0]                instr,
    input  logic                       control_override,
    input  logic                       alu_src_a_sel,
    input  logic [1:0]                 alu_src_b_sel,
    input  logic [BUS_WIDTH-1:0]       pc,
    input  logic [BUS_WIDTH-1:0]       rs1_data,
    input  logic [BUS_WIDTH-1:0]       rs2_data,
    input  logic [BUS_WIDTH-1:0]       mem_rd_data,
    output logic [4:0]                 rs1,
    output logic [4:0]                 rs2,
    output logic [4:0]                 rd,
    output logic [BUS_WIDTH-1:0]       immed,
    output logic [ALU_FUNCT_WIDTH-1:0] alu_funct,
    output logic [BUS_WIDTH-1:0]       alu_result,
    output logic [BUS_WIDTH-1:0]       ex_out,
`ifdef PHILV_ALU_ZERO_FLAG_EN
    output logic                       alu_zero,
    output logic                       ex_zero,
`endif
    output logic [BUS_WIDTH-1:0]       load_data
);

    import philv_pkg::*;

    logic [6:0]           opcode;
    logic [2:0]           funct3;
    logic [BUS_WIDTH-1:0] src_a, src_b;

    assign opcode = instr[OPC_MSB:OPC_LSB];
    assign funct3 = instr[F3_MSB:F3_LSB];
    assign rs1    = instr[RS1_MSB:RS1_LSB];
    assign rs2    = instr[RS2_MSB:RS2_LSB];
    assign rd     = instr[RD_MSB:RD_LSB];

    always_comb begin
        immed = '0;
        case (opcode)
            LOAD, OP_IMM, JALR: immed = {{20{instr[31]}}, instr[31:20]};
            STORE:  immed = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            BRANCH: immed = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                             instr[11:8], 1'b0};
            LUI, AUIPC: immed = {instr[31:12], 12'b0};
            JAL:    immed = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                             instr[30:21], 1'b0};
            default: immed = '0;
        endcase
    end

    // Only shift-right immediates carry the alternate bit, so ADDI never turns into SUB.
    always_comb begin
        alu_funct = ALU_ADD;
        if (control_override)
            alu_funct = ALU_ADD;
        else if (opcode == OP)
            alu_funct = {instr[ALT_BIT], funct3};
        else if (opcode == OP_IMM)
            alu_funct = (funct3 == 3'b101) ? {instr[ALT_BIT], funct3} : {1'b0, funct3};
    end

    always_comb begin
        src_a = (alu_src_a_sel == SRC_A_RS1) ? rs1_data : pc;
        case (alu_src_b_sel)
            SRC_B_RS2:  src_b = rs2_data;
            SRC_B_FOUR: src_b = BUS_WIDTH'(4);
            SRC_B_IMM:  src_b = immed;
            default:    src_b = '0;
        endcase
    end

    philv_alu_core #(.WIDTH(BUS_WIDTH)) u_alu (
        .funct (alu_funct),
        .x     (src_a),
        .y     (src_b),
        .z     (alu_result)
    );

    always_comb begin
        load_data = mem_rd_data;
        if (opcode == LOAD) begin
            case (funct3)
                LD_B:    load_data = {{24{mem_rd_data[7]}}, mem_rd_data[7:0]};
                LD_H:    load_data = {{16{mem_rd_data[15]}}, mem_rd_data[15:0]};
                LD_BU:   load_data = {24'b0, mem_rd_data[7:0]};
                LD_HU:   load_data = {16'b0, mem_rd_data[15:0]};
                default: load_data = mem_rd_data;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) ex_out <= '0;
        else     ex_out <= alu_result;
    end

`ifdef PHILV_ALU_ZERO_FLAG_EN
    assign alu_zero = (alu_result == '0);

    always_ff @(posedge clk) begin
        if (rst) ex_zero <= 1'b0;
        else     ex_zero <= alu_zero;
    end
`endif

endmodule

// File: tb/tb_philv_decode_exec.sv
// Randomized self-checking bench for philv_decode_exec against a field-level
// reference model, plus directed cases for the documented corner values.
module tb_philv_decode_exec;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        control_override;
    logic        alu_src_a_sel;
    logic [1:0]  alu_src_b_sel;
    logic [31:0] pc, rs1_data, rs2_data, mem_rd_data;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] immed, alu_result, ex_out, load_data;
    logic [3:0]  alu_funct;
`ifdef PHILV_ALU_ZERO_FLAG_EN
    logic        alu_zero, ex_zero;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    philv_decode_exec dut (
        .clk              (clk),
        .rst              (rst),
        .instr            (instr),
        .control_override (control_override),
        .alu_src_a_sel    (alu_src_a_sel),
        .alu_src_b_sel    (alu_src_b_sel),
        .pc               (pc),
        .rs1_data         (rs1_data),
        .rs2_data         (rs2_data),
        .mem_rd_data      (mem_rd_data),
        .rs1              (rs1),
        .rs2              (rs2),
        .rd               (rd),
        .immed            (immed),
        .alu_funct        (alu_funct),
        .alu_result       (alu_result),
        .ex_out           (ex_out),
`ifdef PHILV_ALU_ZERO_FLAG_EN
        .alu_zero         (alu_zero),
        .ex_zero          (ex_zero),
`endif
        .load_data        (load_data)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: built from the instruction-format definitions with word
    // shifts and masks rather than bit concatenation.
    function automatic logic [31:0] ref_imm(input logic [31:0] i);
        logic [31:0] s20, s19, s11;
        s20 = $signed(i) >>> 20;
        s19 = $signed(i) >>> 19;
        s11 = $signed(i) >>> 11;
        case (i[6:0])
            7'b0000011, 7'b0010011, 7'b1100111: return s20;
            7'b0100011: return (s20 & 32'hFFFF_FFE0) | ((i >> 7) & 32'h1F);
            7'b1100011: return (s19 & 32'hFFFF_F000) | (((i >> 7) & 1) << 11)
                              | (((i >> 25) & 32'h3F) << 5) | (((i >> 8) & 32'hF) << 1);
            7'b0110111, 7'b0010111: return i & 32'hFFFF_F000;
            7'b1101111: return (s11 & 32'hFFF0_0000) | (i & 32'h000F_F000)
                              | (((i >> 20) & 1) << 11) | (((i >> 21) & 32'h3FF) << 1);
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [3:0] ref_funct(input logic [31:0] i, input logic ovr);
        int f3, alt;
        f3  = (i >> 12) & 7;
        alt = (i >> 30) & 1;
        if (ovr) return 4'd0;
        if (i[6:0] == 7'b0110011) return 4'(alt * 8 + f3);
        if (i[6:0] == 7'b0010011) return 4'((f3 == 5 ? alt * 8 : 0) + f3);
        return 4'd0;
    endfunction

    function automatic logic [31:0] ref_alu(input logic [3:0] f, input logic [31:0] x, input logic [31:0] y);
        int sh;
        sh = y % 32;
        case (f)
            4'd0:  return x + y;
            4'd8:  return x - y;
            4'd1:  return x << sh;
            4'd2:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'd3:  return (x < y) ? 32'd1 : 32'd0;
            4'd4:  return x ^ y;
            4'd5:  return x >> sh;
            4'd13: return $signed(x) >>> sh;
            4'd6:  return x | y;
            4'd7:  return x & y;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] i, input logic [31:0] m);
        if (i[6:0] != 7'b0000011) return m;
        case ((i >> 12) & 7)
            0: return $signed(m << 24) >>> 24;
            1: return $signed(m << 16) >>> 16;
            4: return m & 32'hFF;
            5: return m & 32'hFFFF;
            default: return m;
        endcase
    endfunction

    task automatic apply(input logic [31:0] i, input logic ovr, input logic sa, input logic [1:0] sb,
                         input logic [31:0] p, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] m);
        @(negedge clk);
        instr = i; control_override = ovr; alu_src_a_sel = sa; alu_src_b_sel = sb;
        pc = p; rs1_data = a; rs2_data = b; mem_rd_data = m;
        #1;
    endtask

    logic [6:0] ops [11] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                             7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b0000000,
                             7'b1111111};

    initial begin
        logic [31:0] ei, ex, ey, er;
        logic [3:0]  ef;

        rst = 1'b1;
        apply(32'h0, 1'b0, 1'b0, 2'b00, 0, 0, 0, 0);
        @(posedge clk); #1;
        chk("reset_ex_out", ex_out, 32'h0);
`ifdef PHILV_ALU_ZERO_FLAG_EN
        chk("reset_ex_zero", {31'b0, ex_zero}, 32'h0);
`endif
        rst = 1'b0;

        // ADD x3,x1,x2
        apply(32'h002081B3, 1'b0, 1'b1, 2'b00, 32'h0, 32'd5, 32'd7, 32'h0);
        chk("add_rd", {27'b0, rd}, 32'd3);
        chk("add_funct", {28'b0, alu_funct}, 32'h0);
        chk("add_result", alu_result, 32'd12);
        @(posedge clk); #1;
        chk("add_ex_out", ex_out, 32'd12);

        // SRAI x1,x1,4
        apply(32'h4040D093, 1'b0, 1'b1, 2'b10, 32'h0, 32'h8000_0000, 32'h0, 32'h0);
        chk("srai_imm", immed, 32'h404);
        chk("srai_funct", {28'b0, alu_funct}, 32'hD);
        chk("srai_result", alu_result, 32'hF800_0000);

        // SW x2,-4(x1)
        apply(32'hFE20AE23, 1'b0, 1'b1, 2'b10, 32'h0, 32'h100, 32'h0, 32'h0);
        chk("sw_imm", immed, 32'hFFFF_FFFC);
        chk("sw_funct", {28'b0, alu_funct}, 32'h0);
        chk("sw_result", alu_result, 32'hFC);

        apply(32'h00008083, 1'b0, 1'b1, 2'b10, 0, 0, 0, 32'h0000_0080);
        chk("lb", load_data, 32'hFFFF_FF80);
        apply(32'h0000C083, 1'b0, 1'b1, 2'b10, 0, 0, 0, 32'h0000_0080);
        chk("lbu", load_data, 32'h0000_0080);
        apply(32'h0000D083, 1'b0, 1'b1, 2'b10, 0, 0, 0, 32'h1234_ABCD);
        chk("lhu", load_data, 32'h0000_ABCD);
        apply(32'h0020A1B3, 1'b0, 1'b1, 2'b00, 0, 32'hFFFF_FFFF, 32'd1, 0);
        chk("slt", alu_result, 32'd1);
        apply(32'h0020B1B3, 1'b0, 1'b1, 2'b00, 0, 32'hFFFF_FFFF, 32'd1, 0);
        chk("sltu", alu_result, 32'd0);
        apply(32'h402081B3, 1'b1, 1'b1, 2'b00, 0, 32'd9, 32'd4, 0);
        chk("override_funct", {28'b0, alu_funct}, 32'h0);
        chk("override_result", alu_result, 32'd13);
        // ADDI with bit 30 set must still add
        apply(32'h40108093, 1'b0, 1'b1, 2'b10, 0, 32'd1, 0, 0);
        chk("addi_alt_funct", {28'b0, alu_funct}, 32'h0);
        // pc + 4
        apply(32'h0000006F, 1'b0, 1'b0, 2'b01, 32'h1000, 0, 0, 0);
        chk("pc_plus4", alu_result, 32'h1004);

        // Mid-run reset: ex_out clears for one cycle, then resumes
        apply(32'h002081B3, 1'b0, 1'b1, 2'b11, 0, 32'h55, 32'h0, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_ex_out", ex_out, 32'h0);
        chk("rst_mid_comb", alu_result, 32'h55);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_release_ex_out", ex_out, 32'h55);

        for (int n = 0; n < 400; n++) begin
            ei = $urandom;
            ei[6:0] = ops[$urandom_range(10)];
            apply(ei, ($urandom_range(3) == 0), 1'($urandom), 2'($urandom),
                  $urandom, $urandom, ($urandom_range(3) == 0) ? rs1_data : $urandom, $urandom);
            ef = ref_funct(ei, control_override);
            ex = alu_src_a_sel ? rs1_data : pc;
            case (alu_src_b_sel)
                2'b00: ey = rs2_data;
                2'b01: ey = 32'd4;
                2'b10: ey = ref_imm(ei);
                default: ey = 32'd0;
            endcase
            er = ref_alu(ef, ex, ey);
            chk("rnd_rs1", {27'b0, rs1}, (ei >> 15) & 32'h1F);
            chk("rnd_rs2", {27'b0, rs2}, (ei >> 20) & 32'h1F);
            chk("rnd_rd", {27'b0, rd}, (ei >> 7) & 32'h1F);
            chk("rnd_imm", immed, ref_imm(ei));
            chk("rnd_funct", {28'b0, alu_funct}, {28'b0, ef});
            chk("rnd_result", alu_result, er);
            chk("rnd_load", load_data, ref_load(ei, mem_rd_data));
`ifdef PHILV_ALU_ZERO_FLAG_EN
            chk("rnd_zero", {31'b0, alu_zero}, (er == 0) ? 32'd1 : 32'd0);
`endif
            @(posedge clk); #1;
            chk("rnd_ex_out", ex_out, er);
`ifdef PHILV_ALU_ZERO_FLAG_EN
            chk("rnd_ex_zero", {31'b0, ex_zero}, (er == 0) ? 32'd1 : 32'd0);
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
